ctx_switch_ctrl: RTL and testbench
==================================

# ctx_switch_ctrl

Sequences a full process context switch for the OS layer. When the OS requests a switch, the block:
- saves the running process's register file and PC into a dedicated context memory,
- picks the next ready process round-robin,
- restores that process's registers and PC.

Its `ctx_busy` output is the signal the OS-mode controller already consumes to hold off re-entry into OS mode.

## Interface
Parameters:
- `NUM_REGS`, 32, architectural registers saved/restored (register indices `0..NUM_REGS-1`).
- `NUM_PROCS`, 8, process slots; must be a power of two.
- `PID_W`, 3, `log2(NUM_PROCS)`.
- `IDX_W`, 6, `log2(NUM_REGS)+1`; per-process context stride is `2^IDX_W` words.
- `DATA_W`, 32, register, PC and memory word width.

Ports:
- `clock`  in  1  system clock; single clock domain, rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  switch request; sampled only in IDLE.
- `ready_mask`  in  NUM_PROCS  bit p = process p runnable; sampled in PICK.
- `pc_in`  in  DATA_W  PC of the running process; sampled on the PC save cycle.
- `rf_raddr`  out  5  register file read address.
- `rf_rdata`  in  DATA_W  register file read data; asynchronous read, same cycle.
- `rf_we`  out  1  register file write enable.
- `rf_waddr`  out  5  register file write address.
- `rf_wdata`  out  DATA_W  register file write data.
- `mem_addr`  out  PID_W+IDX_W  context memory address, formed as `{pid, idx}`.
- `mem_we`  out  1  context memory write enable.
- `mem_wdata`  out  DATA_W  context memory write data.
- `mem_rdata`  in  DATA_W  context memory read data; synchronous, valid one cycle after the address.
- `pc_out`  out  DATA_W  restored PC.
- `pc_load`  out  1  one-cycle pulse; `pc_out` is valid in that cycle.
- `cur_pid`  out  PID_W  PID of the running process.
- `ctx_busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at the end of a switch.

## Operation
FSM states:
- **IDLE** → SAVE when `start` is high.
- **SAVE**, index i = 0..NUM_REGS:
  - For i < NUM_REGS: `rf_raddr`=i, `mem_we`=1, `mem_addr`={cur_pid,i}, `mem_wdata`=`rf_rdata`.
  - For i = NUM_REGS: `mem_wdata`=`pc_in`.
  - After i = NUM_REGS → PICK.
- **PICK** (one cycle):
  - `next_pid` = first set bit of `ready_mask`, scanning cur_pid+1, cur_pid+2, … with wrap modulo NUM_PROCS, and cur_pid checked last.
  - If `ready_mask` is all zero, `next_pid`=0 (idle task).
  - → RESTORE.
- **RESTORE**, read index j = 0..NUM_REGS:
  - Each cycle issues `mem_addr`={next_pid,j}, `mem_we`=0.
  - One cycle after a read of j < NUM_REGS: `rf_we`=1, `rf_waddr`=j, `rf_wdata`=`mem_rdata`.
  - One cycle after the read of j = NUM_REGS: `pc_out`=`mem_rdata`, `pc_load`=1.
  - Occupies NUM_REGS+2 cycles, including the drain cycle → DONE.
- **DONE** (one cycle): `done`=1, `cur_pid` updates to `next_pid` at the end of the cycle → IDLE.

Rules:
- Register 0 is saved and restored like any other register; the register file ignores writes to it.
- `start` is ignored while `ctx_busy`=1. It is not queued.
- The switch always runs, even when `next_pid`==`cur_pid`. This is a self-switch: the identical context is rewritten.
- Changes to `ready_mask` outside the PICK cycle have no effect.
- Strobes (`rf_we`, `mem_we`, `pc_load`, `done`) are low in every cycle not listed above.

## Timing
- Reset values:
  - state IDLE.
  - `cur_pid`=0.
  - `ctx_busy`, `done`, `pc_load`, `rf_we`, `mem_we` = 0.
  - All address and data outputs = 0.
- Reset asserted mid-switch: aborts at the next edge and returns to the reset values. A partially saved or restored context is left as-is; no completion pulse.
- Cycle numbering: `start` sampled at edge 0 (this edge moves the FSM from IDLE to SAVE).
- With NUM_REGS=32, cycles below are the cycle following edge n:

| Cycles | Activity |
|---|---|
| 1–33 | SAVE; PC written in cycle 33 |
| 34 | PICK |
| 35–68 | RESTORE reads in 35–67, register writes in 36–67, `pc_load` in 68 |
| 69 | DONE, `done`=1 |
| 70 | IDLE, `ctx_busy`=0; a new `start` is accepted here |

- `ctx_busy` is high in cycles 1–69, i.e. NUM_REGS*2+5 cycles.
- All outputs are registered or decoded from the registered state and index. None depend combinationally on `start`.

## Test plan
- **Basic switch.** Reset; cur_pid=0; `ready_mask`=8'b0000_0100; register file r[i]=i+100; `pc_in`=0x400; pulse `start`.
  - Memory words {0,0..31} = 100..131; word {0,32} = 0x400.
  - Preloaded words {2,i} appear on `rf_wdata` in cycles 36–67.
  - `pc_load` in cycle 68; `done` in cycle 69; `cur_pid`=2 afterwards.
- **Round-robin wrap.** cur_pid=6, `ready_mask`=8'b0100_0001 → next_pid=0. Repeat with cur_pid=0 → next_pid=6.
- **No runnable process.** `ready_mask`=0 → context restored from PID 0; `cur_pid`=0.
- **Self-switch.** `ready_mask` has only the cur_pid bit set → context saved and restored unchanged; `done` still pulses in cycle 69.
- **Ignored start.** Hold `start` high for the whole switch → exactly one switch runs. `ctx_busy` drops in cycle 70; a second switch begins from the IDLE sample in cycle 70.
- **Reset mid-switch.** Assert reset in cycle 20 → the next cycle has `ctx_busy`=0, `mem_we`=0, `cur_pid`=0, and `done` never pulses.

Source files
------------

// File: rtl/ctx_switch_ctrl.sv
// ctx_switch_ctrl
//   Sequences a process context switch: saves the running register file and PC
//   into context memory, picks the next ready process round-robin, then restores
//   that process's registers and PC.
//
// Ports
//   clock, reset       system clock; synchronous active-high reset
//   start              switch request, sampled only in IDLE
//   ready_mask         runnable processes, sampled in PICK
//   pc_in              running PC, sampled on the PC save cycle
//   rf_raddr/rf_rdata  register file read port (asynchronous read)
//   rf_we/waddr/wdata  register file write port
//   mem_addr           context memory address {pid, idx}
//   mem_we/mem_wdata   context memory write port
//   mem_rdata          context memory read data, one cycle after mem_addr
//   pc_out/pc_load     restored PC, valid while pc_load pulses
//   cur_pid            running process
//   ctx_busy           high in every state except IDLE
//   done               one-cycle pulse at the end of a switch
module ctx_switch_ctrl #(
   parameter int NUM_REGS  = 32,
   parameter int NUM_PROCS = 8,
   parameter int PID_W     = 3,
   parameter int IDX_W     = 6,
   parameter int DATA_W    = 32
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   start,
   input  logic [NUM_PROCS-1:0]   ready_mask,
   input  logic [DATA_W-1:0]      pc_in,
   output logic [4:0]             rf_raddr,
   input  logic [DATA_W-1:0]      rf_rdata,
   output logic                   rf_we,
   output logic [4:0]             rf_waddr,
   output logic [DATA_W-1:0]      rf_wdata,
   output logic [PID_W+IDX_W-1:0] mem_addr,
   output logic                   mem_we,
   output logic [DATA_W-1:0]      mem_wdata,
   input  logic [DATA_W-1:0]      mem_rdata,
   output logic [DATA_W-1:0]      pc_out,
   output logic                   pc_load,
   output logic [PID_W-1:0]       cur_pid,
   output logic                   ctx_busy,
   output logic                   done
);

   localparam int RA_W = 5;
   // Index of the PC word in a context, and the restore drain cycle index.
   localparam logic [IDX_W-1:0] PC_IDX    = IDX_W'(NUM_REGS);
   localparam logic [IDX_W-1:0] DRAIN_IDX = IDX_W'(NUM_REGS + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SAVE,
      S_PICK,
      S_RESTORE,
      S_DONE
   } state_t;

   state_t           state, state_nx;
   logic [IDX_W-1:0] idx, idx_nx;
   logic [PID_W-1:0] next_pid;
   logic [PID_W-1:0] pick_pid;
   logic [PID_W-1:0] cand;
   logic             found;

   // State, index and PID registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= S_IDLE;
         idx      <= '0;
         next_pid <= '0;
         cur_pid  <= '0;
      end else begin
         state <= state_nx;
         idx   <= idx_nx;
         if (state == S_PICK) next_pid <= pick_pid;
         if (state == S_DONE) cur_pid  <= next_pid;
      end
   end

   // Round-robin pick: scan cur_pid+1 upward with wrap; the last candidate
   // (k == NUM_PROCS) wraps back to cur_pid itself. No runnable process
   // falls back to PID 0, the idle task.
   always_comb begin
      pick_pid = '0;
      found    = 1'b0;
      cand     = '0;
      for (int k = 1; k <= NUM_PROCS; k++) begin
         cand = cur_pid + PID_W'(k);
         if (!found && ready_mask[cand]) begin
            pick_pid = cand;
            found    = 1'b1;
         end
      end
   end

   // Next state and outputs, decoded from registered state and index only.
   always_comb begin
      state_nx  = state;
      idx_nx    = '0;
      ctx_busy  = (state != S_IDLE);
      rf_raddr  = '0;
      rf_we     = 1'b0;
      rf_waddr  = '0;
      rf_wdata  = '0;
      mem_addr  = '0;
      mem_we    = 1'b0;
      mem_wdata = '0;
      pc_out    = '0;
      pc_load   = 1'b0;
      done      = 1'b0;

      unique case (state)
         S_IDLE: begin
            if (start) state_nx = S_SAVE;
         end

         S_SAVE: begin
            mem_we   = 1'b1;
            mem_addr = {cur_pid, idx};
            if (idx == PC_IDX) begin
               mem_wdata = pc_in;
               state_nx  = S_PICK;
            end else begin
               rf_raddr  = RA_W'(idx);
               mem_wdata = rf_rdata;
               idx_nx    = idx + IDX_W'(1);
            end
         end

         S_PICK: begin
            state_nx = S_RESTORE;
         end

         S_RESTORE: begin
            // Reads are issued at idx; data returns a cycle later, so the
            // write side trails by one index and the last cycle only drains.
            mem_addr = {next_pid, idx};
            if (idx == DRAIN_IDX) begin
               pc_load  = 1'b1;
               pc_out   = mem_rdata;
               state_nx = S_DONE;
            end else begin
               idx_nx = idx + IDX_W'(1);
               if (idx != '0) begin
                  rf_we    = 1'b1;
                  rf_waddr = RA_W'(idx - IDX_W'(1));
                  rf_wdata = mem_rdata;
               end
            end
         end

         S_DONE: begin
            done     = 1'b1;
            state_nx = S_IDLE;
         end

         default: state_nx = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_ctx_switch_ctrl.sv
// tb_ctx_switch_ctrl
//   Scoreboard bench: each switch pushes its expected memory writes, register
//   writes, PC load and done pulse (with the cycle each must appear in) from a
//   reference model; a monitor pops and compares them as the DUT emits them.
module tb_ctx_switch_ctrl;
   localparam int NR = 32, NP = 8, PW = 3, IW = 6, DW = 32, AW = PW + IW;

   logic          clock = 1'b0;
   logic          reset, start;
   logic [NP-1:0] ready_mask;
   logic [DW-1:0] pc_in, rf_rdata, rf_wdata, mem_wdata, mem_rdata, pc_out;
   logic [4:0]    rf_raddr, rf_waddr;
   logic          rf_we, mem_we, pc_load, ctx_busy, done;
   logic [AW-1:0] mem_addr;
   logic [PW-1:0] cur_pid;

   ctx_switch_ctrl #(.NUM_REGS(NR), .NUM_PROCS(NP), .PID_W(PW), .IDX_W(IW), .DATA_W(DW)) dut (
      .clock(clock), .reset(reset), .start(start), .ready_mask(ready_mask), .pc_in(pc_in),
      .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .rf_we(rf_we), .rf_waddr(rf_waddr),
      .rf_wdata(rf_wdata), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .pc_out(pc_out), .pc_load(pc_load), .cur_pid(cur_pid),
      .ctx_busy(ctx_busy), .done(done));

   always #5 clock = ~clock;

   function automatic logic [DW-1:0] init_word(input int a);
      return 32'hA500_0000 + DW'(a * 16 + 1);
   endfunction

   // Environment: register file (async read, r0 ignores writes) and context
   // memory (synchronous read).
   logic          init;
   logic [DW-1:0] rf [NR];
   logic [DW-1:0] ctxmem [1 << AW];
   assign rf_rdata = rf[rf_raddr];
   always @(posedge clock) begin
      if (init) begin
         for (int i = 0; i < NR; i++) rf[i] <= DW'(100 + i);
         for (int a = 0; a < (1 << AW); a++) ctxmem[a] <= init_word(a);
      end else begin
         mem_rdata <= ctxmem[mem_addr];
         if (mem_we) ctxmem[mem_addr] <= mem_wdata;
         if (rf_we && rf_waddr != 5'd0) rf[rf_waddr] <= rf_wdata;
      end
   end

   int ecnt = 0;
   always @(posedge clock) ecnt <= ecnt + 1;

   // Reference model and scoreboard.
   typedef struct {
      int            t;
      int            addr;
      logic [DW-1:0] data;
   } ev_t;
   ev_t           mq[$], rq[$], pq[$], dq[$];
   ev_t           e;
   logic [DW-1:0] ref_rf [NR];
   logic [DW-1:0] ref_mem [1 << AW];
   int            ref_cur;
   int            n_chk = 0, n_err = 0, n_done = 0;
   bit            mon_en = 1'b1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int rr(input int cur, input logic [NP-1:0] m);
      for (int k = 1; k <= NP; k++)
         if (m[(cur + k) % NP]) return (cur + k) % NP;
      return 0;
   endfunction

   // t: ecnt value seen in cycle 1 of the switch; cycle n is seen at t+n-1.
   task automatic push_exp(input int t, input logic [NP-1:0] m, input logic [DW-1:0] pc);
      int cur, nx;
      cur = ref_cur;
      nx  = rr(cur, m);
      for (int i = 0; i < NR; i++) begin
         mq.push_back('{t + i, cur * 64 + i, ref_rf[i]});
         ref_mem[cur * 64 + i] = ref_rf[i];
      end
      mq.push_back('{t + 32, cur * 64 + 32, pc});
      ref_mem[cur * 64 + 32] = pc;
      for (int j = 0; j < NR; j++) begin
         rq.push_back('{t + 35 + j, j, ref_mem[nx * 64 + j]});
         if (j != 0) ref_rf[j] = ref_mem[nx * 64 + j];
      end
      pq.push_back('{t + 67, 0, ref_mem[nx * 64 + 32]});
      dq.push_back('{t + 68, 0, '0});
      ref_cur = nx;
   endtask

   task automatic mon_step();
      if (done) n_done++;
      if (reset || !mon_en) return;
      if (mem_we) begin
         if (mq.size() == 0) chk("mem_we_unexp", 1, 0);
         else begin
            e = mq.pop_front();
            chk("mem_t", ecnt, e.t); chk("mem_addr", mem_addr, e.addr); chk("mem_wdata", mem_wdata, e.data);
         end
      end
      if (rf_we) begin
         if (rq.size() == 0) chk("rf_we_unexp", 1, 0);
         else begin
            e = rq.pop_front();
            chk("rf_t", ecnt, e.t); chk("rf_waddr", rf_waddr, e.addr); chk("rf_wdata", rf_wdata, e.data);
         end
      end
      if (pc_load) begin
         if (pq.size() == 0) chk("pc_load_unexp", 1, 0);
         else begin
            e = pq.pop_front();
            chk("pc_t", ecnt, e.t); chk("pc_out", pc_out, e.data);
         end
      end
      if (done) begin
         if (dq.size() == 0) chk("done_unexp", 1, 0);
         else begin
            e = dq.pop_front();
            chk("done_t", ecnt, e.t);
         end
      end
   endtask

   task automatic end_checks();
      chk("busy_c70", ctx_busy, 0);
      chk("cur_pid", cur_pid, ref_cur);
      chk("sb_drain", mq.size() + rq.size() + pq.size() + dq.size(), 0);
   endtask

   // Called at a negedge in IDLE; returns at the negedge of cycle 70.
   task automatic do_switch(input logic [NP-1:0] m, input logic [DW-1:0] pc);
      push_exp(ecnt + 1, m, pc);
      ready_mask = m; pc_in = pc; start = 1'b1;
      @(negedge clock);                          // cycle 1
      start = 1'b0;
      chk("busy_c1", ctx_busy, 1);
      repeat (34) @(negedge clock);              // cycle 35, PICK is over
      ready_mask = ~m;
      repeat (34) @(negedge clock);              // cycle 69
      chk("busy_c69", ctx_busy, 1);
      @(negedge clock);                          // cycle 70
      end_checks();
   endtask

   initial begin
      int nd0, t1;
      init = 1'b1; reset = 1'b1; start = 1'b0; ready_mask = '0; pc_in = '0;
      for (int i = 0; i < NR; i++) ref_rf[i] = DW'(100 + i);
      for (int a = 0; a < (1 << AW); a++) ref_mem[a] = init_word(a);
      ref_cur = 0;
      fork
         forever begin
            @(negedge clock);
            mon_step();
         end
      join_none
      @(negedge clock);
      init = 1'b0;
      repeat (2) @(negedge clock);
      chk("rst_busy", ctx_busy, 0); chk("rst_done", done, 0); chk("rst_pc_load", pc_load, 0);
      chk("rst_rf_we", rf_we, 0); chk("rst_mem_we", mem_we, 0); chk("rst_cur_pid", cur_pid, 0);
      chk("rst_mem_addr", mem_addr, 0); chk("rst_rf_raddr", rf_raddr, 0); chk("rst_pc_out", pc_out, 0);
      reset = 1'b0;
      @(negedge clock);

      // Basic switch 0 -> 2.
      do_switch(8'b0000_0100, 32'h400);
      for (int i = 0; i < NR; i++) chk("basic_saved_reg", ctxmem[i], 100 + i);
      chk("basic_saved_pc", ctxmem[32], 32'h400);
      chk("basic_pid", cur_pid, 2);

      // Round-robin wrap.
      do_switch(8'b0100_0000, 32'h600);
      chk("to_6", cur_pid, 6);
      do_switch(8'b0100_0001, 32'h601);
      chk("wrap_6_0", cur_pid, 0);
      do_switch(8'b0100_0001, 32'h602);
      chk("wrap_0_6", cur_pid, 6);

      // No runnable process -> idle task.
      do_switch(8'b0000_0000, 32'h603);
      chk("idle_task", cur_pid, 0);

      // Self-switch.
      do_switch(8'b0000_0001, 32'h604);
      chk("self_pid", cur_pid, 0);
      chk("self_pc_saved", ctxmem[32], 32'h604);

      // Start held high: one switch, then a second from the IDLE cycle.
      t1 = ecnt + 1;
      push_exp(t1, 8'b0000_1000, 32'h700);
      ready_mask = 8'b0000_1000; pc_in = 32'h700; start = 1'b1;
      repeat (69) @(negedge clock);              // cycle 69
      chk("hold_busy_c69", ctx_busy, 1);
      @(negedge clock);                          // cycle 70
      chk("hold_busy_c70", ctx_busy, 0);
      chk("hold_pid_1", cur_pid, 3);
      push_exp(t1 + 70, 8'b0000_1000, 32'h800);
      pc_in = 32'h800;
      @(negedge clock);                          // cycle 1 of second switch
      start = 1'b0;
      chk("hold_busy_2nd", ctx_busy, 1);
      repeat (69) @(negedge clock);
      end_checks();
      chk("hold_pid_2", cur_pid, 3);

      // Reset in cycle 20 aborts the switch.
      mon_en = 1'b0;
      nd0 = n_done;
      ready_mask = 8'b0000_0001; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      repeat (19) @(negedge clock);              // cycle 20
      chk("mid_busy_before", ctx_busy, 1);
      reset = 1'b1;
      @(negedge clock);                          // cycle 21
      chk("abort_busy", ctx_busy, 0); chk("abort_mem_we", mem_we, 0);
      chk("abort_cur_pid", cur_pid, 0); chk("abort_done", done, 0);
      reset = 1'b0;
      repeat (75) @(negedge clock);
      chk("abort_no_done", n_done - nd0, 0);
      chk("abort_idle", ctx_busy, 0);
      ref_cur = 0;
      mon_en = 1'b1;

      // Recovery switch after the abort.
      do_switch(8'b0000_0010, 32'h900);
      chk("recover_pid", cur_pid, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
